display_scaler: RTL and testbench

- Parametrised successor to the VGA scan-out display block. Generates VGA timing from a video_mode_t and reads a framebuffer described by a buffer_config_t.
- Adds runtime integer up-scaling (1x/2x/4x/8x) with a border colour outside the scaled image, and two framebuffer pages with tear-free page flip at vblank.
- Adds a configurable framebuffer read latency with matched sync delay, two pixel formats, and frame/line status pulses.
- Sits between the framebuffer read port and the VGA pins, in the pixel clock domain.

---
 rtl/display_scaler_if.sv | 54 +++++
 rtl/display_scaler.sv | 142 ++++++++++++++
 tb/tb_display_scaler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/display_scaler_if.sv
// rtl/display_scaler_if.sv - timing/buffer types and the framebuffer + VGA pin bundle
package display_scaler_pkg;
  typedef struct packed {
    int   h_res;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_res;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;   // 1 = sync pulse is high
    logic vs_pol;
  } video_mode_t;

  typedef struct packed {
    int width;
    int height;
    int data_width;
  } buffer_config_t;

  localparam video_mode_t VMODE_640x480p60 = '{
    h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_res: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam buffer_config_t BUFFER_160x120x12 = '{width: 160, height: 120, data_width: 12};
endpackage

interface display_scaler_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              vga_hsync;
  logic              vga_vsync;
  logic [3:0]        vga_red;
  logic [3:0]        vga_green;
  logic [3:0]        vga_blue;

  modport master (
    output read_addr,
    input  read_data,
    output vga_hsync, vga_vsync, vga_red, vga_green, vga_blue
  );

  modport slave (
    input  read_addr,
    output read_data,
    input  vga_hsync, vga_vsync, vga_red, vga_green, vga_blue
  );
endinterface

// File: rtl/display_scaler.sv
// rtl/display_scaler.sv - VGA scan-out with integer up-scaling, border, page flip and read-latency matching
module display_scaler
  import display_scaler_pkg::*;
#(
  parameter video_mode_t    VIDEO_MODE    = VMODE_640x480p60,
  parameter buffer_config_t BUFFER_CONFIG = BUFFER_160x120x12,
  parameter int PAGES        = 2,
  parameter int READ_LATENCY = 1,
  parameter int PIXEL_FORMAT = 0,
  parameter int ADDR_W       = $clog2(PAGES * BUFFER_CONFIG.width * BUFFER_CONFIG.height)
) (
  input  logic        clk_pixel,
  input  logic        rstn_pixel,
  input  logic [1:0]  cfg_scale_shift,
  input  logic        cfg_page_req,
  input  logic [11:0] border_color,
  output logic        active_page,
  output logic        frame_start,
  output logic        vblank,
  display_scaler_if.master vga
);
  localparam int H_RES  = VIDEO_MODE.h_res;
  localparam int V_RES  = VIDEO_MODE.v_res;
  localparam int LW     = H_RES + VIDEO_MODE.h_fp + VIDEO_MODE.h_sync + VIDEO_MODE.h_bp;
  localparam int LH     = V_RES + VIDEO_MODE.v_fp + VIDEO_MODE.v_sync + VIDEO_MODE.v_bp;
  localparam int HS_BEG = H_RES + VIDEO_MODE.h_fp;
  localparam int HS_END = HS_BEG + VIDEO_MODE.h_sync;
  localparam int VS_BEG = V_RES + VIDEO_MODE.v_fp;
  localparam int VS_END = VS_BEG + VIDEO_MODE.v_sync;
  localparam int W      = BUFFER_CONFIG.width;
  localparam int H      = BUFFER_CONFIG.height;
  localparam int XW     = $clog2(LW);
  localparam int YW     = $clog2(LH);
  localparam int NFL    = 5;

  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [1:0]     scale_q;
  logic [1:0]     s_eff;
  logic           page_eff;
  logic           first_px;
  logic [31:0]    x32, y32, xs, ys, addr32;
  logic           de0, in_img0, hs0, vs0;
  logic [NFL-1:0] flag_pipe [READ_LATENCY+1];
  logic           f_de, f_img, f_hs, f_vs, f_fs;
  logic [3:0]     pix_r, pix_g, pix_b;

  // The frame's first pixel already uses the newly requested scale/page,
  // so the whole frame is consistent and flips never tear.
  always_comb begin
    x32      = 32'(x);
    y32      = 32'(y);
    first_px = (x == '0) && (y == '0);
    s_eff    = first_px ? cfg_scale_shift : scale_q;
    page_eff = (PAGES > 1) && (first_px ? cfg_page_req : active_page);
    xs       = x32 >> s_eff;
    ys       = y32 >> s_eff;
    de0      = (x32 < 32'(H_RES)) && (y32 < 32'(V_RES));
    in_img0  = de0 && (xs < 32'(W)) && (ys < 32'(H));
    hs0      = (x32 >= 32'(HS_BEG)) && (x32 < 32'(HS_END));
    vs0      = (y32 >= 32'(VS_BEG)) && (y32 < 32'(VS_END));
    addr32   = (page_eff ? 32'(W * H) : 32'd0) + ys * 32'(W) + xs;
  end

  assign vblank = y32 >= 32'(V_RES);

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      x <= '0;
      y <= '0;
    end else if (x == XW'(LW - 1)) begin
      x <= '0;
      y <= (y == YW'(LH - 1)) ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      scale_q     <= '0;
      active_page <= 1'b0;
    end else if (first_px) begin
      scale_q     <= cfg_scale_shift;
      active_page <= page_eff;
    end
  end

  // Timing flags ride alongside the fetch so they meet read_data at the last stage.
  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      vga.read_addr <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) flag_pipe[i] <= '0;
    end else begin
      vga.read_addr <= in_img0 ? ADDR_W'(addr32) : '0;
      flag_pipe[0]  <= {de0, in_img0, hs0, vs0, first_px};
      for (int i = 1; i <= READ_LATENCY; i++) flag_pipe[i] <= flag_pipe[i-1];
    end
  end

  assign {f_de, f_img, f_hs, f_vs, f_fs} = flag_pipe[READ_LATENCY];

  generate
    if (PIXEL_FORMAT == 1) begin : g_rgb332
      assign pix_r = {vga.read_data[2:0], vga.read_data[2]};
      assign pix_g = {vga.read_data[5:3], vga.read_data[5]};
      assign pix_b = {vga.read_data[7:6], vga.read_data[7:6]};
    end else begin : g_rgb444
      assign pix_r = vga.read_data[3:0];
      assign pix_g = vga.read_data[7:4];
      assign pix_b = vga.read_data[11:8];
    end
  endgenerate

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      vga.vga_hsync <= ~VIDEO_MODE.hs_pol;
      vga.vga_vsync <= ~VIDEO_MODE.vs_pol;
      vga.vga_red   <= '0;
      vga.vga_green <= '0;
      vga.vga_blue  <= '0;
      frame_start   <= 1'b0;
    end else begin
      vga.vga_hsync <= f_hs ? VIDEO_MODE.hs_pol : ~VIDEO_MODE.hs_pol;
      vga.vga_vsync <= f_vs ? VIDEO_MODE.vs_pol : ~VIDEO_MODE.vs_pol;
      frame_start   <= f_fs;
      if (!f_de) begin
        vga.vga_red   <= '0;
        vga.vga_green <= '0;
        vga.vga_blue  <= '0;
      end else if (!f_img) begin
        vga.vga_red   <= border_color[3:0];
        vga.vga_green <= border_color[7:4];
        vga.vga_blue  <= border_color[11:8];
      end else begin
        vga.vga_red   <= pix_r;
        vga.vga_green <= pix_g;
        vga.vga_blue  <= pix_b;
      end
    end
  end
endmodule

// File: tb/tb_display_scaler.sv
// tb/tb_display_scaler.sv - directed checks of timing, scaling, border, page flip, latency and reset
module tb_display_scaler;
  import display_scaler_pkg::*;

  localparam video_mode_t TB_MODE = '{
    h_res: 40, h_fp: 4, h_sync: 6, h_bp: 6,
    v_res: 30, v_fp: 2, v_sync: 2, v_bp: 2,
    hs_pol: 1'b0, vs_pol: 1'b0
  };
  localparam buffer_config_t BUF_A = '{width: 10, height: 8, data_width: 12};
  localparam buffer_config_t BUF_B = '{width: 10, height: 8, data_width: 8};
  localparam int LW    = 56;
  localparam int FRAME = 56 * 36;

  logic        clk_pixel;
  logic        rstn_pixel;
  logic [1:0]  a_scale, b_scale;
  logic        a_page, b_page;
  logic [11:0] a_border, b_border;
  logic        a_active, a_fs, a_vblank;
  logic        b_active, b_fs, b_vblank;
  logic [7:0]  b_d1, b_d2;

  int n;
  int n_cmp;
  int n_err;

  display_scaler_if #(.ADDR_W(8), .DATA_W(12)) bus_a ();
  display_scaler_if #(.ADDR_W(7), .DATA_W(8))  bus_b ();

  display_scaler #(
    .VIDEO_MODE(TB_MODE), .BUFFER_CONFIG(BUF_A), .PAGES(2),
    .READ_LATENCY(1), .PIXEL_FORMAT(0), .ADDR_W(8)
  ) dut_a (
    .clk_pixel(clk_pixel), .rstn_pixel(rstn_pixel),
    .cfg_scale_shift(a_scale), .cfg_page_req(a_page), .border_color(a_border),
    .active_page(a_active), .frame_start(a_fs), .vblank(a_vblank), .vga(bus_a)
  );

  display_scaler #(
    .VIDEO_MODE(TB_MODE), .BUFFER_CONFIG(BUF_B), .PAGES(1),
    .READ_LATENCY(3), .PIXEL_FORMAT(1), .ADDR_W(7)
  ) dut_b (
    .clk_pixel(clk_pixel), .rstn_pixel(rstn_pixel),
    .cfg_scale_shift(b_scale), .cfg_page_req(b_page), .border_color(b_border),
    .active_page(b_active), .frame_start(b_fs), .vblank(b_vblank), .vga(bus_b)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  // Framebuffer models: A returns its address after 1 cycle, B returns address ^ 8'hD5 after 3.
  always @(posedge clk_pixel) begin
    bus_a.read_data <= {4'h0, bus_a.read_addr};
    b_d1            <= {1'b0, bus_b.read_addr} ^ 8'hD5;
    b_d2            <= b_d1;
    bus_b.read_data <= b_d2;
  end

  always @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) n <= 0;
    else             n <= n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int t);
    int guard = 0;
    while (n != t && guard < 3 * FRAME) begin
      @(negedge clk_pixel);
      guard++;
    end
    if (n != t) check("wait_timeout", n, t);
  endtask

  // Waits until the output p stages downstream of the counter shows pixel (px,py).
  task automatic wait_px(input int px, input int py, input int p);
    int k = py * LW + px + p;
    while (k < n) k += FRAME;
    wait_n(k);
  endtask

  function automatic logic [11:0] col_a();
    return {bus_a.vga_red, bus_a.vga_green, bus_a.vga_blue};
  endfunction

  function automatic logic [11:0] col_b();
    return {bus_b.vga_red, bus_b.vga_green, bus_b.vga_blue};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn_pixel = 1'b1;
    a_scale = 2'd2; a_page = 1'b0; a_border = 12'hF00;
    b_scale = 2'd1; b_page = 1'b1; b_border = 12'h0A0;
    #2 rstn_pixel = 1'b0;
    repeat (3) @(negedge clk_pixel);

    check("rst_hsync",  bus_a.vga_hsync, 1);
    check("rst_vsync",  bus_a.vga_vsync, 1);
    check("rst_color",  col_a(), 12'h000);
    check("rst_addr",   bus_a.read_addr, 0);
    check("rst_fs",     a_fs, 0);
    check("rst_page",   a_active, 0);
    check("rst_vblank", a_vblank, 0);
    check("rst_b_hs",   bus_b.vga_hsync, 1);
    rstn_pixel = 1'b1;

    // Frame 0: 4x scale, page 0
    wait_px(0, 0, 3);   check("fs_first", a_fs, 1);
    wait_px(1, 0, 3);   check("fs_one_cycle", a_fs, 0);
    wait_px(4, 0, 1);   check("addr_x4", bus_a.read_addr, 1);
    wait_px(43, 0, 3);  check("hs_before", bus_a.vga_hsync, 1);
    wait_px(44, 0, 3);  check("hs_first", bus_a.vga_hsync, 0);
    wait_px(49, 0, 3);  check("hs_last", bus_a.vga_hsync, 0);
    wait_px(50, 0, 3);  check("hs_after", bus_a.vga_hsync, 1);
    wait_px(0, 4, 1);   check("addr_y4", bus_a.read_addr, 10);
    wait_px(45, 5, 3);  check("blank_black", col_a(), 12'h000);
    wait_px(39, 10, 3); check("img_s2", col_a(), 12'hD10);
    wait_px(55, 29, 0); check("vblank_lo", a_vblank, 0);
    wait_px(0, 30, 0);  check("vblank_hi", a_vblank, 1);
    wait_px(0, 31, 3);  check("vs_before", bus_a.vga_vsync, 1);
    wait_px(0, 32, 3);  check("vs_first", bus_a.vga_vsync, 0);
    wait_px(55, 33, 3); check("vs_last", bus_a.vga_vsync, 0);
    wait_px(0, 34, 3);  check("vs_after", bus_a.vga_vsync, 1);
    a_scale = 2'd1;

    // Frame 1: 2x scale, page request raised mid-frame
    wait_px(0, 0, 3);   check("frame_period", a_fs, 1);
    wait_px(19, 0, 3);  check("img_edge_x", col_a(), 12'h900);
    wait_px(20, 0, 3);  check("border_x", col_a(), 12'h00F);
    wait_px(0, 10, 0);  a_page = 1'b1;
    wait_px(0, 15, 3);  check("img_edge_y", col_a(), 12'h640);
    wait_px(0, 16, 3);  check("border_y", col_a(), 12'h00F);
    wait_px(0, 20, 0);  check("page_hold", a_active, 0);
    a_scale = 2'd3;

    // Frame 2: 8x scale clipped to the active area, page 1
    wait_px(0, 0, 1);   check("addr_page1", bus_a.read_addr, 80);
    wait_px(1, 0, 0);   check("page_flip", a_active, 1);
    wait_px(39, 0, 3);  check("s3_no_border", col_a(), 12'h450);
    wait_px(39, 29, 1); check("s3_addr_max", bus_a.read_addr, 114);
    wait_px(39, 29, 3); check("s3_corner", col_a(), 12'h270);

    // Frame 3: RGB332 with 3-cycle read latency, single page
    wait_px(0, 0, 5);   check("b_fs", b_fs, 1);
                        check("b_rgb332", col_b(), 12'hB4F);
    wait_px(2, 0, 5);   check("b_align", col_b(), 12'h94F);
    wait_px(19, 0, 5);  check("b_img_edge", col_b(), 12'h96F);
    wait_px(20, 0, 5);  check("b_border", col_b(), 12'h0A0);
    wait_px(43, 0, 5);  check("b_hs_before", bus_b.vga_hsync, 1);
    wait_px(44, 0, 5);  check("b_hs_first", bus_b.vga_hsync, 0);
                        check("b_page_ignored", b_active, 0);

    // Reset mid-frame, then restart timing
    wait_px(10, 20, 0);
    rstn_pixel = 1'b0;
    #1;
    check("mid_rst_addr",  bus_a.read_addr, 0);
    check("mid_rst_color", col_a(), 12'h000);
    check("mid_rst_page",  a_active, 0);
    check("mid_rst_hsync", bus_a.vga_hsync, 1);
    check("mid_rst_b_col", col_b(), 12'h000);
    repeat (2) @(negedge clk_pixel);
    rstn_pixel = 1'b1;
    wait_n(2);  check("rel_fs_early", a_fs, 0);
    wait_n(3);  check("rel_fs_p3", a_fs, 1);
    wait_n(4);  check("rel_b_fs_early", b_fs, 0);
    wait_n(5);  check("rel_b_fs_p5", b_fs, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
